alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal 4..64).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: op  input  4  opcode.
REQ-009 SHALL have port: out_valid  output  1  result fields valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  WIDTH  registered result.
REQ-012 SHALL have ports (output, 1 each): zero (result==0), ovf (overflow), branch (BEQ taken), illegal (unsupported opcode).

Function
REQ-013 SHALL accept an operation on a rising edge where in_valid && in_ready, capturing a, b, op.
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (IDLE) || (DONE && out_ready).
REQ-015 SHALL, for single-cycle ops, move to DONE on the accept edge: out_valid high the next cycle (latency 1); back-to-back accepts give one result per cycle.
REQ-016 SHALL decode op: 0000 ADD, 0001 SUB, 0010 XOR, 0011 BEQ, 0100 OR, 0101 AND, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLT (signed, result 1/0), 1010 MUL.
REQ-017 SHALL set ovf for ADD/SUB to two's-complement signed overflow of the WIDTH-bit result; ovf=0 for all logic/shift/SLT/BEQ ops.
REQ-018 SHALL use b[$clog2(WIDTH)-1:0] as shift amount for SLL/SRL/SRA; upper b bits ignored.
REQ-019 SHALL, for BEQ, output result=0 and branch=(a==b); branch=0 for every other op.
REQ-020 SHALL, for unused opcodes (1011-1111), output result=0, illegal=1, ovf=0, latency 1; illegal=0 otherwise.
REQ-021 SHALL compute zero from the registered result (zero = result==0) at all times.
REQ-022 SHALL hold result/zero/ovf/branch/illegal stable while out_valid && !out_ready.
REQ-023 SHALL, in DONE with out_ready && !in_valid, go to IDLE and drop out_valid the next cycle.
REQ-024 SHALL keep in_ready low in BUSY; in_valid during BUSY is ignored, not queued.
REQ-025 SHALL, in DONE with out_ready && in_valid, retire the current result and accept the new op on the same edge.

Reset
REQ-026 SHALL, on reset asserted, immediately force state=IDLE, out_valid=0, result=0, ovf=0, branch=0, illegal=0 (zero=1), independent of clk.
REQ-027 SHALL abort an in-progress MUL on reset mid-operation; no result is ever delivered for it.
REQ-028 SHALL drive in_ready=0 while reset is asserted and 1 from the first clk edge after deassertion.

Configuration
REQ-029 SHALL, with macro ALU_MC_MUL_EN defined, implement MUL as an iterative shift-add unsigned multiplier: accept->BUSY for exactly WIDTH cycles->DONE; result = low WIDTH bits of a*b; ovf=1 iff high WIDTH bits nonzero.
REQ-030 SHALL, without ALU_MC_MUL_EN, treat op 1010 as illegal per REQ-020 with no multiplier logic synthesised.

Verification
REQ-031 SHALL cover (WIDTH=32): ADD a=0x7FFFFFFF b=1 -> result 0x80000000, ovf=1, zero=0, out_valid one cycle after accept.
REQ-032 SHALL cover: SUB a=5 b=5 then BEQ a=7 b=7 back-to-back, out_ready=1 -> consecutive cycles result 0/zero=1, then result 0/branch=1; in_ready stays 1.
REQ-033 SHALL cover: SRA a=0x80000000 b=0x24 (shift 4) -> 0xF8000000; op=1111 -> result 0, illegal=1.
REQ-034 SHALL cover: out_ready=0 for 3 cycles after XOR 0xF0F0 ^ 0x0FF0 -> result 0xFF00 held stable, in_ready=0, then one-cycle retire on out_ready=1.
REQ-035 SHALL cover (ALU_MC_MUL_EN): MUL 0x10000 * 0x10000 -> out_valid 33 cycles after accept, result 0, ovf=1, zero=1; MUL 3*4 -> 12, ovf=0.
REQ-036 SHALL cover: reset pulsed mid-MUL (cycle 10 of BUSY) -> outputs zeroed asynchronously, no out_valid afterwards until a new op is accepted.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready request and result handshake.
// Optional iterative shift-add multiplier on op 1010 when ALU_MC_MUL_EN is defined.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             branch,
    output logic             illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_BEQ = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1010;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rdy_en_q, rdy_en_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             branch_q, branch_d;
    logic             illegal_q, illegal_d;

    logic             accept_c;
    logic             start_mul_c;
    logic             mul_last_c;

    logic [WIDTH-1:0] alu_res_c;
    logic             alu_ovf_c;
    logic             alu_br_c;
    logic             alu_ill_c;
    logic [SHW-1:0]   shamt_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_c) state_d = start_mul_c ? BUSY : DONE;
            BUSY: if (mul_last_c) state_d = DONE;
            DONE: begin
                if (accept_c)       state_d = start_mul_c ? BUSY : DONE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; in_ready stays low until the first edge after reset
    always_comb begin
        in_ready  = 1'b0;
        out_valid = (state_q == DONE);
        if (rdy_en_q && !reset)
            in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    end

    assign accept_c = in_valid && in_ready;

    // Single-cycle operation results
    always_comb begin
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        alu_br_c  = 1'b0;
        alu_ill_c = 1'b0;
        shamt_c   = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                alu_res_c = a + b;
                alu_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c = a - b;
                alu_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: alu_res_c = a ^ b;
            OP_BEQ: alu_br_c  = (a == b);
            OP_OR:  alu_res_c = a | b;
            OP_AND: alu_res_c = a & b;
            OP_SLL: alu_res_c = a << shamt_c;
            OP_SRL: alu_res_c = a >> shamt_c;
            OP_SRA: alu_res_c = $unsigned($signed(a) >>> shamt_c);
            OP_SLT: alu_res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MC_MUL_EN
            OP_MUL: alu_res_c = '0;
`endif
            default: alu_ill_c = 1'b1;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum_c;
    logic [2*WIDTH-1:0] prod_step_c;

    assign start_mul_c = accept_c && (op == OP_MUL);
    assign mul_last_c  = (state_q == BUSY) && (cnt_q == SHW'(WIDTH - 1));

    // One shift-add step: conditionally add multiplicand to the high half, then shift right
    always_comb begin
        mul_sum_c   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
        prod_step_c = {mul_sum_c, prod_q[WIDTH-1:1]};
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        if (start_mul_c) begin
            prod_d  = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            prod_d = prod_step_c;
            cnt_d  = cnt_q + SHW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign start_mul_c = 1'b0;
    assign mul_last_c  = 1'b0;
`endif

    // Result registers: load on single-cycle accept or multiplier completion, otherwise hold
    always_comb begin
        rdy_en_d  = 1'b1;
        result_d  = result_q;
        ovf_d     = ovf_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        if (accept_c && !start_mul_c) begin
            result_d  = alu_res_c;
            ovf_d     = alu_ovf_c;
            branch_d  = alu_br_c;
            illegal_d = alu_ill_c;
        end
`ifdef ALU_MC_MUL_EN
        else if (mul_last_c) begin
            result_d  = prod_step_c[WIDTH-1:0];
            ovf_d     = |prod_step_c[2*WIDTH-1:WIDTH];
            branch_d  = 1'b0;
            illegal_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_en_q  <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            rdy_en_q  <= rdy_en_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = (result_q == '0);
    assign ovf     = ovf_q;
    assign branch  = branch_q;
    assign illegal = illegal_q;

endmodule
